tdc_sum_averager: RTL and testbench
===================================

# tdc_sum_averager

Downstream stage of the 8-channel TDC summing multiplier. Accepts the 20-bit per-shot channel sum and its one-cycle valid pulse, and accumulates 2^LOG2_N consecutive shots. It then emits a rounded average plus the block min/max over a valid/ready output handshake. It also counts results lost to back-pressure.

## Interface
- LOG2_N, 4, log2 of shots per average block; legal 1..8
- IN_W, 20, input sum width; must match the summing stage output
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_sum  in  IN_W  per-shot channel sum, unsigned, sampled only when in_dval=1
- in_dval  in  1  input valid; a single-cycle pulse per shot, may occur on consecutive cycles
- acc_clr  in  1  synchronous clear of the block in progress and of the output
- out_avg  out  IN_W  rounded block average
- out_min  out  IN_W  smallest in_sum of the block
- out_max  out  IN_W  largest in_sum of the block
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result when out_valid && out_ready at a clock edge
- ovr_cnt  out  8  saturating count of results dropped due to back-pressure
- busy  out  1  state is ACCUM

## Operation
- States: IDLE (no samples in block) and ACCUM (1..N-1 samples held); N = 2^LOG2_N.
- Accumulator acc: IN_W+LOG2_N bits, unsigned, never overflows.
- Sample counter cnt: LOG2_N bits.
- IDLE + in_dval:
  - acc <= in_sum; min <= max <= in_sum; cnt <= 1.
  - Next state ACCUM. If N would be reached (never for LOG2_N≥1), no special case.
- ACCUM + in_dval with cnt < N-1:
  - acc += in_sum; cnt++.
  - min/max update with in_sum, unsigned compare.
- ACCUM + in_dval with cnt == N-1 (block completes):
  - Final sum S = acc + in_sum; final min/max include in_sum.
  - Result avg = (S + 2^(LOG2_N-1)) >> LOG2_N, truncated to IN_W bits, no overflow possible.
  - acc, cnt cleared; state returns to IDLE at the same edge.
- Result load rule, at the completion edge:
  - If out_valid=0, or out_ready=1: out_avg/out_min/out_max load, out_valid <= 1.
  - Otherwise: new result is discarded, old result stays, ovr_cnt increments and saturates at 255.
- Consumption: out_valid && out_ready with no completion at the same edge -> out_valid <= 0. Data outputs hold their last value.
- acc_clr:
  - Forces IDLE, acc=0, cnt=0, out_valid=0.
  - ovr_cnt is not cleared.
  - acc_clr wins over a simultaneous in_dval; that sample is lost.
- in_dval is ignored in no state; the input is never back-pressured.

## Timing
- Reset values: out_avg=0, out_min=0, out_max=0, out_valid=0, ovr_cnt=0, busy=0, state IDLE.
- Latency: out_valid is high in the cycle following the edge that captured the Nth in_dval. There is one register stage; the rounding add is in the same cycle as the final accumulate.
- Throughput: one sample per clock sustained; back-to-back blocks have no dead cycle.
- The sample after a completing edge starts the next block from IDLE.
- Reset asserted mid-block discards the partial block and any pending result immediately (asynchronous).
- Outputs are registered; there are no combinational paths from in_* or out_ready to outputs.

## Structure
- Shared package tdc_pkg holds:
  - TDC_SUM_W = 20 (used by the summing stage and this block)
  - avg_state_t enum {IDLE, ACCUM}
  - OVR_CNT_W = 8
- One natural sub-module: tdc_minmax_trk.
  - Parameter W; inputs load, upd, din; outputs min, max.
  - load overrides upd.
  - Instantiated once and also reusable per-channel elsewhere.
- The rest (FSM, accumulator, output handshake, overflow counter) lives in tdc_sum_averager.

## Test plan
- LOG2_N=2, out_ready=1:
  - Stimulus: in_dval pulses with 10, 20, 30, 41.
  - Response: one cycle later, out_valid=1, out_avg=25 ((101+2)>>2), out_min=10, out_max=41. out_valid drops the next cycle.
- Rounding and full range, LOG2_N=2:
  - Four samples of 0xFFFFF -> out_avg=0xFFFFF.
  - Samples 1, 1, 1, 0 -> out_avg=1.
  - Samples 1, 0, 0, 0 -> out_avg=0.
- Back-pressure, out_ready=0, LOG2_N=2:
  - Stimulus: two full blocks (avg 5 then avg 9).
  - Response: out_avg stays 5, ovr_cnt=1.
  - Raising out_ready clears out_valid after one edge.
  - 300 dropped blocks -> ovr_cnt=255.
- Simultaneous accept and completion:
  - out_ready=1 on the same edge the next block completes -> out_valid stays 1, out_avg switches to the new value, ovr_cnt unchanged.
- acc_clr after 3 of 4 samples, asserted together with a 4th in_dval:
  - No result is produced; busy=0.
  - The next 4 samples (8 each) give out_avg=8.
- Asynchronous rst mid-block with out_valid=1:
  - All outputs go to 0 immediately.
  - The following block of 4 samples produces a correct average.

Source files
------------

// File: rtl/tdc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tdc_pkg: shared widths and state type for the TDC summing chain  (rev 1.0)
// ----------------------------------------------------------------------------
package tdc_pkg;

  localparam int TDC_SUM_W = 20;
  localparam int OVR_CNT_W = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } avg_state_t;

endpackage
`default_nettype wire

// File: rtl/tdc_sum_averager_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tdc_sum_averager_if: shot input, clear and result handshake bundle  (rev 1.0)
// ----------------------------------------------------------------------------
interface tdc_sum_averager_if
  import tdc_pkg::*;
#(
  parameter int IN_W = TDC_SUM_W
);

  logic [IN_W-1:0]      in_sum;
  logic                 in_dval;
  logic                 acc_clr;
  logic [IN_W-1:0]      out_avg;
  logic [IN_W-1:0]      out_min;
  logic [IN_W-1:0]      out_max;
  logic                 out_valid;
  logic                 out_ready;
  logic [OVR_CNT_W-1:0] ovr_cnt;
  logic                 busy;

  modport master (
    output in_sum, in_dval, acc_clr, out_ready,
    input  out_avg, out_min, out_max, out_valid, ovr_cnt, busy
  );

  modport slave (
    input  in_sum, in_dval, acc_clr, out_ready,
    output out_avg, out_min, out_max, out_valid, ovr_cnt, busy
  );

endinterface
`default_nettype wire

// File: rtl/tdc_minmax_trk.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tdc_minmax_trk: running unsigned min/max tracker, load overrides upd  (rev 1.0)
// ----------------------------------------------------------------------------
module tdc_minmax_trk #(
  parameter int W = 20
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         load,
  input  wire logic         upd,
  input  wire logic [W-1:0] din,
  output logic      [W-1:0] min,
  output logic      [W-1:0] max
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min <= '0;
      max <= '0;
    end else if (load) begin
      min <= din;
      max <= din;
    end else if (upd) begin
      if (din < min) min <= din;
      if (din > max) max <= din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tdc_sum_averager.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tdc_sum_averager: 2^LOG2_N shot block average with min/max and drop count  (rev 1.0)
// ----------------------------------------------------------------------------
module tdc_sum_averager
  import tdc_pkg::*;
#(
  parameter int LOG2_N = 4,
  parameter int IN_W   = TDC_SUM_W
) (
  input wire logic          clk,
  input wire logic          rst,
  tdc_sum_averager_if.slave bus
);

  localparam int                c_N        = 1 << LOG2_N;
  localparam int                c_ACC_W    = IN_W + LOG2_N;
  localparam logic [LOG2_N-1:0] c_CNT_LAST = LOG2_N'(c_N - 1);
  localparam logic [c_ACC_W-1:0] c_HALF    = c_ACC_W'(c_N / 2);

  avg_state_t           r_state;
  avg_state_t           w_state_nxt;
  logic [c_ACC_W-1:0]   r_acc;
  logic [LOG2_N-1:0]    r_cnt;
  logic                 w_take_idle;
  logic                 w_take_acc;
  logic                 w_done;
  logic                 w_out_free;
  logic [c_ACC_W-1:0]   w_sum_fin;
  logic [c_ACC_W-1:0]   w_sum_rnd;
  logic [IN_W-1:0]      w_avg;
  logic [IN_W-1:0]      w_trk_min;
  logic [IN_W-1:0]      w_trk_max;
  logic [IN_W-1:0]      w_fin_min;
  logic [IN_W-1:0]      w_fin_max;
  logic [IN_W-1:0]      r_out_avg;
  logic [IN_W-1:0]      r_out_min;
  logic [IN_W-1:0]      r_out_max;
  logic                 r_out_valid;
  logic [OVR_CNT_W-1:0] r_ovr_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take_idle = 1'b0;
    w_take_acc  = 1'b0;
    w_done      = 1'b0;
    if (bus.acc_clr) begin
      w_state_nxt = IDLE;
    end else if (bus.in_dval) begin
      case (r_state)
        IDLE: begin
          w_take_idle = 1'b1;
          w_state_nxt = ACCUM;
        end
        ACCUM: begin
          w_take_acc = 1'b1;
          if (r_cnt == c_CNT_LAST) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // The accumulator is wide enough for N full-scale shots plus the rounding half.
  assign w_sum_fin = r_acc + c_ACC_W'(bus.in_sum);
  assign w_sum_rnd = w_sum_fin + c_HALF;
  assign w_avg     = IN_W'(w_sum_rnd >> LOG2_N);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (bus.acc_clr || w_done) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_take_idle) begin
      r_acc <= c_ACC_W'(bus.in_sum);
      r_cnt <= LOG2_N'(1);
    end else if (w_take_acc) begin
      r_acc <= w_sum_fin;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  tdc_minmax_trk #(
    .W (IN_W)
  ) u_minmax (
    .clk  (clk),
    .rst  (rst),
    .load (w_take_idle),
    .upd  (w_take_acc),
    .din  (bus.in_sum),
    .min  (w_trk_min),
    .max  (w_trk_max)
  );

  // The tracker lags by one edge, so fold in the completing shot here.
  assign w_fin_min  = (bus.in_sum < w_trk_min) ? bus.in_sum : w_trk_min;
  assign w_fin_max  = (bus.in_sum > w_trk_max) ? bus.in_sum : w_trk_max;
  assign w_out_free = !r_out_valid || bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_avg   <= '0;
      r_out_min   <= '0;
      r_out_max   <= '0;
      r_out_valid <= 1'b0;
      r_ovr_cnt   <= '0;
    end else if (bus.acc_clr) begin
      r_out_valid <= 1'b0;
    end else if (w_done) begin
      if (w_out_free) begin
        r_out_avg   <= w_avg;
        r_out_min   <= w_fin_min;
        r_out_max   <= w_fin_max;
        r_out_valid <= 1'b1;
      end else if (r_ovr_cnt != '1) begin
        r_ovr_cnt <= r_ovr_cnt + 1'b1;
      end
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_avg   = r_out_avg;
  assign bus.out_min   = r_out_min;
  assign bus.out_max   = r_out_max;
  assign bus.out_valid = r_out_valid;
  assign bus.ovr_cnt   = r_ovr_cnt;
  assign bus.busy      = (r_state == ACCUM);

endmodule
`default_nettype wire

// File: tb/tb_tdc_sum_averager.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_tdc_sum_averager: directed plus random checks against a block-level model  (rev 1.0)
// ----------------------------------------------------------------------------
module tb_tdc_sum_averager;
  import tdc_pkg::*;

  localparam int LOG2_N = 2;
  localparam int N      = 1 << LOG2_N;
  localparam int IN_W   = TDC_SUM_W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tdc_sum_averager_if #(.IN_W(IN_W)) bus ();

  tdc_sum_averager #(
    .LOG2_N (LOG2_N),
    .IN_W   (IN_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  int unsigned q[$];
  logic        m_valid = 1'b0;
  int unsigned m_avg = 0, m_min = 0, m_max = 0, m_ovr = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic check_all(input string ph);
    check_val({ph, ".valid"}, 32'(bus.out_valid), 32'(m_valid));
    check_val({ph, ".busy"},  32'(bus.busy),      32'(q.size() != 0));
    check_val({ph, ".ovr"},   32'(bus.ovr_cnt),   m_ovr);
    check_val({ph, ".avg"},   32'(bus.out_avg),   m_avg);
    check_val({ph, ".min"},   32'(bus.out_min),   m_min);
    check_val({ph, ".max"},   32'(bus.out_max),   m_max);
  endtask

  task automatic model_reset();
    q.delete();
    m_valid = 1'b0;
    m_avg = 0; m_min = 0; m_max = 0; m_ovr = 0;
  endtask

  // Block-level behaviour: collect N shots, then publish or drop the result.
  task automatic model_edge(input bit dval, input int unsigned s, input bit clr, input bit rdy);
    bit          done = 1'b0;
    int unsigned tot, mn, mx;
    if (clr) begin
      q.delete();
      m_valid = 1'b0;
      return;
    end
    if (dval) begin
      q.push_back(s);
      if (q.size() == N) begin
        tot = 0; mn = q[0]; mx = q[0];
        foreach (q[i]) begin
          tot += q[i];
          if (q[i] < mn) mn = q[i];
          if (q[i] > mx) mx = q[i];
        end
        q.delete();
        done = 1'b1;
        if (!m_valid || rdy) begin
          m_avg = (tot + N / 2) / N;
          m_min = mn;
          m_max = mx;
          m_valid = 1'b1;
        end else if (m_ovr < 255) begin
          m_ovr++;
        end
      end
    end
    if (!done && m_valid && rdy) m_valid = 1'b0;
  endtask

  task automatic cyc(input string tag, input bit dval, input int unsigned s,
                     input bit clr, input bit rdy);
    bus.in_dval   = dval;
    bus.in_sum    = IN_W'(s);
    bus.acc_clr   = clr;
    bus.out_ready = rdy;
    @(posedge clk);
    model_edge(dval, s, clr, rdy);
    #1;
    check_all(tag);
  endtask

  task automatic block4(input string tag, input int unsigned a, input int unsigned b,
                        input int unsigned c, input int unsigned d, input bit rdy);
    cyc(tag, 1'b1, a, 1'b0, rdy);
    cyc(tag, 1'b1, b, 1'b0, rdy);
    cyc(tag, 1'b1, c, 1'b0, rdy);
    cyc(tag, 1'b1, d, 1'b0, rdy);
  endtask

  initial begin
    bus.in_dval   = 1'b0;
    bus.in_sum    = '0;
    bus.acc_clr   = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    block4("basic", 10, 20, 30, 41, 1'b1);
    check_val("basic_avg", 32'(bus.out_avg), 25);
    check_val("basic_min", 32'(bus.out_min), 10);
    check_val("basic_max", 32'(bus.out_max), 41);
    cyc("basic_drop", 1'b0, 0, 1'b0, 1'b1);

    block4("full", 'hFFFFF, 'hFFFFF, 'hFFFFF, 'hFFFFF, 1'b1);
    check_val("full_avg", 32'(bus.out_avg), 'hFFFFF);
    block4("rnd_up", 1, 1, 1, 0, 1'b1);
    check_val("rnd_up_avg", 32'(bus.out_avg), 1);
    block4("rnd_dn", 1, 0, 0, 0, 1'b1);
    check_val("rnd_dn_avg", 32'(bus.out_avg), 0);
    cyc("idle", 1'b0, 0, 1'b0, 1'b1);

    block4("bp1", 5, 5, 5, 5, 1'b0);
    block4("bp2", 9, 9, 9, 9, 1'b0);
    check_val("bp_avg", 32'(bus.out_avg), 5);
    check_val("bp_ovr", 32'(bus.ovr_cnt), 1);
    cyc("bp_accept", 1'b0, 0, 1'b0, 1'b1);
    check_val("bp_accept_valid", 32'(bus.out_valid), 0);

    block4("sim_a", 3, 3, 3, 3, 1'b0);
    cyc("sim_b", 1'b1, 7, 1'b0, 1'b0);
    cyc("sim_b", 1'b1, 7, 1'b0, 1'b0);
    cyc("sim_b", 1'b1, 7, 1'b0, 1'b0);
    cyc("sim_b", 1'b1, 7, 1'b0, 1'b1);
    check_val("sim_valid", 32'(bus.out_valid), 1);
    check_val("sim_avg", 32'(bus.out_avg), 7);
    check_val("sim_ovr", 32'(bus.ovr_cnt), 1);

    for (int k = 0; k < 300; k++) block4("drop", k, k + 1, k + 2, k + 3, 1'b0);
    check_val("sat_ovr", 32'(bus.ovr_cnt), 255);
    cyc("drain", 1'b0, 0, 1'b0, 1'b1);

    cyc("clr", 1'b1, 100, 1'b0, 1'b1);
    cyc("clr", 1'b1, 100, 1'b0, 1'b1);
    cyc("clr", 1'b1, 100, 1'b0, 1'b1);
    cyc("clr", 1'b1, 100, 1'b1, 1'b1);
    check_val("clr_busy", 32'(bus.busy), 0);
    check_val("clr_valid", 32'(bus.out_valid), 0);
    block4("post_clr", 8, 8, 8, 8, 1'b1);
    check_val("post_clr_avg", 32'(bus.out_avg), 8);

    block4("pre_rst", 40, 50, 60, 70, 1'b0);
    cyc("pre_rst", 1'b1, 11, 1'b0, 1'b0);
    cyc("pre_rst", 1'b1, 12, 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #2 rst = 1'b0;
    block4("post_rst", 2, 4, 6, 9, 1'b1);
    check_val("post_rst_avg", 32'(bus.out_avg), 5);

    for (int k = 0; k < 2000; k++) begin
      int unsigned s;
      case ($urandom_range(7))
        0:       s = 0;
        1:       s = 'hFFFFF;
        default: s = $urandom & 32'hFFFFF;
      endcase
      cyc("rand", $urandom_range(3) != 0, s, $urandom_range(63) == 0, $urandom_range(1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
